// File: rtl/proc_run_pkg.sv
// rtl/proc_run_pkg.sv - shared state encoding and width helpers for the run controller
package proc_run_pkg;

   typedef enum logic [1:0] {IDLE, RSTSEQ, RUN, DONE} run_state_e;

   // Index/counter width that stays at least 1 bit for single-entry cases
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/proc_watch_match.sv
// rtl/proc_watch_match.sv - combinational address watchpoint comparator, lowest index wins
module proc_watch_match
   import proc_run_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int NUM_WATCH = 2
) (
   input  logic [ADDR_W-1:0]             bus_addr,
   input  logic [NUM_WATCH*ADDR_W-1:0]   watch_addr,
   input  logic [NUM_WATCH-1:0]          watch_en,
   output logic                          match,
   output logic [idx_w(NUM_WATCH)-1:0]   match_idx
);

   localparam int IDX_W = idx_w(NUM_WATCH);

   // Scan downward so the last assignment made is the lowest matching entry
   always_comb begin
      match     = 1'b0;
      match_idx = '0;
      for (int i = NUM_WATCH - 1; i >= 0; i--) begin
         if (watch_en[i] && (watch_addr[i*ADDR_W +: ADDR_W] == bus_addr)) begin
            match     = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/proc_run_ctrl.sv
// rtl/proc_run_ctrl.sv - processor reset/run sequencer with watchpoint stop and timeout
module proc_run_ctrl
   import proc_run_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RST_CYCLES = 2,
   parameter int MAX_CYCLES = 20,
   parameter int NUM_WATCH  = 2,
   parameter int CNT_W      = $clog2(MAX_CYCLES + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [ADDR_W-1:0]             bus_addr,
   input  logic [DATA_W-1:0]             bus_data,
   input  logic [NUM_WATCH*ADDR_W-1:0]   watch_addr,
   input  logic [NUM_WATCH-1:0]          watch_en,
   output logic                          proc_rst,
   output logic                          running,
   output logic                          done,
   output logic                          timeout,
   output logic                          hit,
   output logic [idx_w(NUM_WATCH)-1:0]   hit_idx,
   output logic [DATA_W-1:0]             hit_data,
   output logic [CNT_W-1:0]              cycle_count
);

   localparam int IDX_W = idx_w(NUM_WATCH);
   localparam int RC_W  = idx_w(RST_CYCLES);

   run_state_e          state_q, state_d;
   logic [RC_W-1:0]     rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
   logic                timeout_q, timeout_d;
   logic                hit_q, hit_d;
   logic [IDX_W-1:0]    hit_idx_q, hit_idx_d;
   logic [DATA_W-1:0]   hit_data_q, hit_data_d;

   logic                match;
   logic [IDX_W-1:0]    match_idx;
   logic                last_rst;
   logic                last_run;

   proc_watch_match #(
      .ADDR_W    (ADDR_W),
      .NUM_WATCH (NUM_WATCH)
   ) u_match (
      .bus_addr   (bus_addr),
      .watch_addr (watch_addr),
      .watch_en   (watch_en),
      .match      (match),
      .match_idx  (match_idx)
   );

   assign last_rst = (rst_cnt_q == RC_W'(RST_CYCLES - 1));
   assign last_run = (cycle_count_q == CNT_W'(MAX_CYCLES - 1));

   always_comb begin
      state_d       = state_q;
      rst_cnt_d     = rst_cnt_q;
      cycle_count_d = cycle_count_q;
      timeout_d     = timeout_q;
      hit_d         = hit_q;
      hit_idx_d     = hit_idx_q;
      hit_data_d    = hit_data_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d       = RSTSEQ;
               rst_cnt_d     = '0;
               cycle_count_d = '0;
               timeout_d     = 1'b0;
               hit_d         = 1'b0;
               hit_idx_d     = '0;
               hit_data_d    = '0;
            end
         end
         RSTSEQ: begin
            if (last_rst) begin
               state_d   = RUN;
               rst_cnt_d = '0;
            end else begin
               rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
         end
         RUN: begin
            // A hit in the final budget cycle takes precedence over timeout
            if (match) begin
               state_d    = DONE;
               hit_d      = 1'b1;
               hit_idx_d  = match_idx;
               hit_data_d = bus_data;
            end else if (last_run) begin
               state_d   = DONE;
               timeout_d = 1'b1;
            end else begin
               cycle_count_d = cycle_count_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d       = IDLE;
         rst_cnt_d     = '0;
         cycle_count_d = '0;
         timeout_d     = 1'b0;
         hit_d         = 1'b0;
         hit_idx_d     = '0;
         hit_data_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         rst_cnt_q     <= '0;
         cycle_count_q <= '0;
         timeout_q     <= 1'b0;
         hit_q         <= 1'b0;
         hit_idx_q     <= '0;
         hit_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         rst_cnt_q     <= rst_cnt_d;
         cycle_count_q <= cycle_count_d;
         timeout_q     <= timeout_d;
         hit_q         <= hit_d;
         hit_idx_q     <= hit_idx_d;
         hit_data_q    <= hit_data_d;
      end
   end

   // Decoded from the state flop so async reset forces proc_rst high at once
   assign proc_rst    = (state_q != RUN);
   assign running     = (state_q == RUN);
   assign done        = (state_q == DONE);
   assign timeout     = timeout_q;
   assign hit         = hit_q;
   assign hit_idx     = hit_idx_q;
   assign hit_data    = hit_data_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: doc/proc_run_ctrl.md
Name: proc_run_ctrl

Overview:
- Synthesisable run controller for the unicycle processor (processorTop).
- Sequences processor reset, lets the core run for a bounded number of cycles, and watches the core's address/data bus against NUM_WATCH programmable address watchpoints.
- Stops on the first watchpoint hit or on timeout, and reports cycle count and captured data.
- Used on-board and in regression benches in place of fixed-delay reset/finish sequencing.

Parameters:
- ADDR_W, 32, width of the monitored address bus
- DATA_W, 32, width of the monitored data bus
- RST_CYCLES, 2, cycles proc_rst is held high after start (min 1)
- MAX_CYCLES, 20, run-cycle budget before timeout (min 1)
- NUM_WATCH, 2, number of address watchpoints (min 1)
- CNT_W, $clog2(MAX_CYCLES+1), width of cycle_count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a run; honoured in IDLE and DONE only
- abort  in  1  force return to IDLE from any state
- bus_addr  in  ADDR_W  processor address bus
- bus_data  in  DATA_W  processor data bus
- watch_addr  in  NUM_WATCH*ADDR_W  packed watch addresses; entry i at [i*ADDR_W +: ADDR_W]
- watch_en  in  NUM_WATCH  per-entry enable
- proc_rst  out  1  active-high reset to processor
- running  out  1  high in RUN
- done  out  1  high in DONE
- timeout  out  1  run ended by budget exhaustion
- hit  out  1  run ended by watchpoint
- hit_idx  out  $clog2(NUM_WATCH) (min 1)  index of the matching entry
- hit_data  out  DATA_W  bus_data captured on the hit cycle
- cycle_count  out  CNT_W  RUN cycles elapsed

Behaviour:
- Reset values:
  - State: IDLE.
  - Outputs: proc_rst=1; running, done, timeout, hit, hit_idx, hit_data and cycle_count all 0.
- IDLE:
  - proc_rst=1.
  - start=1 at an edge moves to RSTSEQ. On that transition, timeout, hit, hit_idx, hit_data and cycle_count are cleared.
- RSTSEQ:
  - proc_rst=1 for exactly RST_CYCLES cycles, tracked by an internal counter.
  - Then moves to RUN.
- RUN:
  - proc_rst=0, running=1.
  - cycle_count is 0 in the first RUN cycle and increments by 1 per cycle.
  - Each cycle, compare bus_addr with every entry that has watch_en set.
  - On a match:
    - The lowest matching index wins.
    - At the next edge: move to DONE, hit=1, hit_idx=index, hit_data=bus_data of the matching cycle.
    - cycle_count freezes at its value in the matching cycle.
  - On timeout:
    - Condition: no match and cycle_count==MAX_CYCLES-1.
    - At the next edge: move to DONE, timeout=1, cycle_count stays MAX_CYCLES-1.
  - Match and timeout in the same cycle: the hit wins, timeout=0.
- DONE:
  - done=1, proc_rst=1 (core frozen).
  - Result outputs hold their values.
  - start=1 restarts exactly as from IDLE.
- abort:
  - Takes priority over every transition, including start.
  - Next state IDLE, proc_rst=1.
  - Result outputs are cleared to reset values.
- start while in RSTSEQ or RUN: ignored.
- watch_en all zero: the run can only end by timeout or abort.
- Async reset mid-run: immediate return to reset values. proc_rst rises combinationally with the reset assertion, so it is driven from the registered state.
- No combinational path from bus_* to any output; all outputs are registered.

Decomposition:
- Package proc_run_pkg holds:
  - the state typedef: enum logic [1:0] {IDLE, RSTSEQ, RUN, DONE};
  - localparam helper functions for the index width.
- Sub-module proc_watch_match: combinational priority comparator.
  - Parameters: ADDR_W, NUM_WATCH.
  - Inputs: bus_addr, watch_addr, watch_en.
  - Outputs: match and match_idx.
- The FSM, counters and capture registers live in proc_run_ctrl.

Test Plan:
- Reset then idle: rst low 2 cycles then high, no start. Required: proc_rst=1, done=0 and all results 0 for 10 cycles.
- Timeout (defaults, watch_en=0): pulse start. Required: proc_rst=1 for exactly 2 cycles, then running for 20 cycles; done=1, timeout=1, cycle_count=19, hit=0.
- Single hit (defaults): watch_addr[0]=32'h0000_0010, watch_en=2'b01; drive bus_addr=32'h10 and bus_data=32'hDEAD_BEEF in run cycle 5. Required next cycle: done=1, hit=1, hit_idx=0, hit_data=32'hDEADBEEF, cycle_count=5, proc_rst=1.
- Priority and collision:
  - Both entries set to 32'h24 and enabled. Required: hit_idx=0.
  - Rerun with the match in cycle 19. Required: hit=1, timeout=0.
- Abort mid-run: abort in run cycle 3. Required next cycle: state IDLE, proc_rst=1, running=0, cycle_count=0. A start asserted together with abort is ignored.
- Async reset and restart:
  - Drop rst mid-RUN between clock edges. Required: proc_rst=1 and running=0 immediately.
  - After release, start from DONE. Required: results cleared on entry to RSTSEQ and a full 2-cycle reset sequence repeats.
